ones_count_datapath: RTL and testbench
======================================

# ones_count_datapath

Datapath companion to the ones-counter control FSM. It accepts one operand over a valid/ready input port, holds it in a shift register, and counts its set bits under the control strobes `Load_En`, `shift_En`, `count_Load` and `out_En`. It returns the status flags `Aeq10` and `n_0` to the FSM and presents the final count on a valid/ready output port.

## Interface
- `WIDTH`, default 8: operand width, must be at least 2.
- `CW`, default $clog2(WIDTH+1): count and result width, derived and not to be overridden.

- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_data`, input, WIDTH: operand.
- `in_valid`, input, 1: operand offered.
- `in_ready`, output, 1: operand accepted on `in_valid && in_ready`.
- `Load_En`, input, 1: load A from the operand path and clear the count.
- `shift_En`, input, 1: shift A right by 1 (logical).
- `count_Load`, input, 1: increment the count.
- `out_En`, input, 1: FSM is in its output state.
- `Aeq10`, output, 1: A == 0, combinational from the A register.
- `n_0`, output, 1: A[0], combinational from the A register.
- `out_data`, output, CW: result count.
- `out_valid`, output, 1: result offered.
- `out_ready`, input, 1: result accepted on `out_valid && out_ready`.
- `load_underrun`, output, 1: sticky flag; a `Load_En` arrived with no operand available.

## Operation
- **Registers:** A[WIDTH], cnt[CW], buf[WIDTH], buf_valid, out_data, out_valid, sent, load_underrun.
- **Reset values:** every register is 0. Consequences after reset:
  - `in_ready` = 1
  - `Aeq10` = 1, `n_0` = 0
  - `out_valid` = 0, `out_data` = 0, `load_underrun` = 0
- **Operand buffer:** one entry.
  - `in_ready = !buf_valid || Load_En`.
  - An accept writes buf and sets buf_valid.
- **Operand source on `Load_En`,** in priority order:
  1. buf_valid = 1: A <= buf, and buf_valid clears. If an accept happens in the same cycle, buf is refilled instead and buf_valid stays 1.
  2. buf empty and `in_valid` = 1: A <= in_data (bypass). This counts as that cycle's accept, and the buffer is not written.
  3. Neither: A <= 0 and `load_underrun` <= 1.
- **On `Load_En` also:** cnt <= 0, sent <= 0, out_valid <= 0.
- **Priority rules:**
  - `Load_En` overrides `shift_En` and `count_Load` in the same cycle.
  - `shift_En` and `count_Load` together both take effect: A shifts, and cnt increments using the pre-shift value.
- **Counter:** increments by 1 and saturates at WIDTH, never wrapping. Reaching saturation is legal only when the operand is all ones.
- **Output capture:** on `out_En && !out_valid && !sent`, out_data <= cnt and out_valid <= 1.
- **Output hold:**
  - out_data and out_valid stay stable while `out_valid && !out_ready`.
  - A handshake clears out_valid and sets sent on the next edge.
  - Further `out_En` cycles are ignored until the next `Load_En` or `rst`.
- **`load_underrun`:** cleared only by `rst`.
- **Reset mid-operation:** all registers return to their reset values immediately and asynchronously. Any operand held in buf is discarded. Any result not yet handshaken is lost.

## Timing
- **Flags:** `Aeq10` and `n_0` reflect A in the same cycle, with no register stage. The FSM samples them in its decision state.
- **A:** updates on the edge ending the strobe cycle. The new value is visible on the flags in the following cycle.
- **FSM step costs:** each operand bit costs 2 cycles (decision + shift), or 3 cycles if the bit is 1 (decision + increment + shift).
- **Latency:** k = index of the highest set bit, p = popcount, t0 = the `Load_En` cycle.
  - Operand nonzero: out_valid rises at t0 + 2(k+1) + p + 3.
  - Operand zero: out_valid rises at t0 + 3.
- **Input path:** no combinational path from `in_valid` to `in_ready` except through `Load_En`. The output port has no combinational path from `out_ready` to `out_valid`.
- **Throughput:** one operand per `rst`/`Load_En` cycle. The FSM stays in its output state until reset.

## Test plan
- **Popcount of 0xB5:** hold `in_valid`=1 with in_data=0xB5 across reset release, with the FSM attached and `out_ready`=1. Required: the operand is accepted in the `Load_En` cycle, out_valid rises at t0+24 with out_data=5, and `load_underrun`=0.
- **Zero operand:** in_data=0x00. Required: `Aeq10`=1 at t0+1, out_valid at t0+3, out_data=0.
- **All ones:** in_data=0xFF. Required: out_data=8 (saturation boundary) at t0+27, with no wrap to 0.
- **Underrun:** hold `in_valid`=0 through `Load_En`. Required: `load_underrun`=1 from t0+1, A=0, out_data=0. A later `in_valid` is accepted into buf (`in_ready` falls the cycle after the accept).
- **Output backpressure:** with operand 0x03, hold `out_ready`=0 for 3 cycles after out_valid rises. Required: out_valid=1 and out_data=2 stay stable. On `out_ready`=1, out_valid clears the next cycle and never reasserts.
- **Reset mid-count:** with operand 0xF0, assert `rst` at t0+10. Required: immediately A=0, out_valid=0, `in_ready`=1, `load_underrun`=0. After release, a fresh operand 0x81 yields out_data=2.

Source files
------------

// File: rtl/ones_count_datapath.sv
// ones_count_datapath
// Datapath half of the ones-counter: a one-entry operand buffer feeding a
// shift register A, a saturating bit counter, and a registered result port
// with valid/ready handshake. Control strobes come from an external FSM,
// which reads back the Aeq10 (A == 0) and n_0 (A[0]) flags.

module ones_count_datapath #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Load_En,
  input  logic             shift_En,
  input  logic             count_Load,
  input  logic             out_En,
  output logic             Aeq10,
  output logic             n_0,
  output logic [CW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             load_underrun
);

  // Saturation value of the counter: an all-ones operand of WIDTH bits.
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_valid_q, buf_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sent_q, sent_d;
  logic             load_underrun_q, load_underrun_d;
  logic             accept_s;

  // A Load_En frees the buffer slot in the same cycle, so ready may follow it.
  assign in_ready = !buf_valid_q || Load_En;
  assign accept_s = in_valid && in_ready;

  // Status flags are read straight off A so the FSM sees them in its decision state.
  assign Aeq10 = (a_q == {WIDTH{1'b0}});
  assign n_0   = a_q[0];

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign load_underrun = load_underrun_q;

  // Operand buffer, shift register A and underrun flag next-state.
  always_comb begin
    a_d             = a_q;
    buf_d           = buf_q;
    buf_valid_d     = buf_valid_q;
    load_underrun_d = load_underrun_q;
    if (Load_En) begin
      if (buf_valid_q) begin
        // Buffered operand wins; a concurrent accept refills the slot.
        a_d = buf_q;
        if (accept_s) begin
          buf_d       = in_data;
          buf_valid_d = 1'b1;
        end else begin
          buf_valid_d = 1'b0;
        end
      end else if (in_valid) begin
        // Bypass: the accept of this cycle goes straight into A.
        a_d = in_data;
      end else begin
        a_d             = {WIDTH{1'b0}};
        load_underrun_d = 1'b1;
      end
    end else begin
      // Outside a load, ready implies an empty slot, so an accept fills it.
      if (accept_s) begin
        buf_d       = in_data;
        buf_valid_d = 1'b1;
      end else begin
        buf_d       = buf_q;
      end
      if (shift_En) begin
        a_d = a_q >> 1;
      end else begin
        a_d = a_q;
      end
    end
  end

  // Bit counter next-state: cleared by a load, saturating increment otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (Load_En) begin
      cnt_d = {CW{1'b0}};
    end else if (count_Load && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Result port next-state: capture once per operand, hold under backpressure.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sent_d      = sent_q;
    if (Load_En) begin
      out_valid_d = 1'b0;
      sent_d      = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      sent_d      = 1'b1;
    end else if (out_En && !out_valid_q && !sent_q) begin
      out_data_d  = cnt_q;
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any buffered operand and pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q             <= {WIDTH{1'b0}};
      buf_q           <= {WIDTH{1'b0}};
      buf_valid_q     <= 1'b0;
      cnt_q           <= {CW{1'b0}};
      out_data_q      <= {CW{1'b0}};
      out_valid_q     <= 1'b0;
      sent_q          <= 1'b0;
      load_underrun_q <= 1'b0;
    end else begin
      a_q             <= a_d;
      buf_q           <= buf_d;
      buf_valid_q     <= buf_valid_d;
      cnt_q           <= cnt_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
      sent_q          <= sent_d;
      load_underrun_q <= load_underrun_d;
    end
  end

endmodule

// File: tb/tb_ones_count_datapath.sv
// Self-checking bench for ones_count_datapath. A small behavioural model of
// the control FSM drives the strobes; expected counts go into a scoreboard
// queue at load time and are compared when the result handshake occurs.

module tb_ones_count_datapath;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       Load_En;
  logic       shift_En;
  logic       count_Load;
  logic       out_En;
  logic       Aeq10;
  logic       n_0;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       load_underrun;

  ones_count_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .Load_En(Load_En), .shift_En(shift_En), .count_Load(count_Load), .out_En(out_En),
    .Aeq10(Aeq10), .n_0(n_0),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .load_underrun(load_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {F_LOAD, F_TEST, F_INC, F_SHIFT, F_OUT} fst_t;
  fst_t fst;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] p = 4'd0;
    for (int i = 0; i < 8; i++) if (v[i]) p = p + 4'd1;
    return p;
  endfunction

  // Cycles from the Load_En cycle to the first cycle out_valid is seen high.
  function automatic int exp_lat(input logic [7:0] v);
    int k = -1;
    for (int i = 0; i < 8; i++) if (v[i]) k = i;
    if (k < 0) return 3;
    return 2 * (k + 1) + int'(popcnt(v)) + 3;
  endfunction

  task automatic drive_strobes();
    Load_En    = (fst == F_LOAD);
    count_Load = (fst == F_INC);
    shift_En   = (fst == F_SHIFT);
    out_En     = (fst == F_OUT);
  endtask

  task automatic fsm_next();
    case (fst)
      F_LOAD:  fst = F_TEST;
      F_TEST:  fst = Aeq10 ? F_OUT : (n_0 ? F_INC : F_SHIFT);
      F_INC:   fst = F_SHIFT;
      F_SHIFT: fst = F_TEST;
      default: fst = F_OUT;
    endcase
  endtask

  // One full operand: load, FSM-driven count, result handshake, then idle checks.
  task automatic run_op(input logic iv, input logic [7:0] id, input logic [7:0] op,
                        input int dly, input logic exp_urun, input logic exp_rdy1);
    int rise = -1;
    int hs   = -1;
    exp_q.push_back(popcnt(op));
    fst = F_LOAD;
    for (int c = 0; c < 80; c++) begin
      in_valid  = (c == 0) ? iv : 1'b0;
      in_data   = id;
      out_ready = (dly == 0) || (rise >= 0 && c >= rise + dly);
      drive_strobes();
      @(negedge clk);
      if (c == 0) chk("rdy_load", 32'(in_ready), 32'd1);
      if (c == 1) begin
        chk("aeq0_t1", 32'(Aeq10), 32'(op == 8'h00));
        chk("n0_t1", 32'(n_0), 32'(op[0]));
        chk("urun_t1", 32'(load_underrun), 32'(exp_urun));
        chk("rdy_t1", 32'(in_ready), 32'(exp_rdy1));
      end
      if (out_valid && rise < 0) begin
        rise = c;
        chk("latency", 32'(c), 32'(exp_lat(op)));
      end
      if (rise >= 0 && hs < 0) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() > 0) chk("hold_data", 32'(out_data), 32'(exp_q[0]));
      end
      if (out_valid && out_ready) begin
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) chk("result", 32'(out_data), 32'(exp_q.pop_front()));
        hs = c;
      end else if (hs >= 0) begin
        chk("no_revalid", 32'(out_valid), 32'd0);
      end
      fsm_next();
      @(posedge clk);
      #1;
      if (hs >= 0 && c >= hs + 4) break;
    end
    chk("hs_seen", 32'(hs >= 0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hB5; out_ready = 1'b1;
    Load_En = 1'b0; shift_En = 1'b0; count_Load = 1'b0; out_En = 1'b0;
    fst = F_LOAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_aeq0", 32'(Aeq10), 32'd1);
    chk("rst_n0", 32'(n_0), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_odata", 32'(out_data), 32'd0);
    chk("rst_urun", 32'(load_underrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 0xB5 held across reset release: bypassed in the Load_En cycle.
    run_op(1'b1, 8'hB5, 8'hB5, 0, 1'b0, 1'b1);
    // Zero operand.
    run_op(1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b1);
    // All ones: saturation boundary.
    run_op(1'b1, 8'hFF, 8'hFF, 0, 1'b0, 1'b1);
    // Underrun: no operand at Load_En.
    run_op(1'b0, 8'h5A, 8'h00, 0, 1'b1, 1'b1);

    // Later offer lands in the buffer; ready drops the cycle after the accept.
    in_valid = 1'b1; in_data = 8'h03;
    drive_strobes();
    @(negedge clk);
    chk("rdy_empty", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rdy_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;

    // Load 0x03 from the buffer under backpressure; 0xF0 refills it concurrently.
    run_op(1'b1, 8'hF0, 8'h03, 3, 1'b1, 1'b0);

    // Reset mid-count: load 0xF0 from the buffer, assert rst at t0+10.
    exp_q.push_back(popcnt(8'hF0));
    fst = F_LOAD;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_strobes();
      @(negedge clk);
      if (c == 1) begin
        chk("buf_src_aeq0", 32'(Aeq10), 32'd0);
        chk("buf_src_rdy", 32'(in_ready), 32'd1);
      end
      fsm_next();
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_aeq0", 32'(Aeq10), 32'd1);
    chk("mid_n0", 32'(n_0), 32'd0);
    chk("mid_ovalid", 32'(out_valid), 32'd0);
    chk("mid_rdy", 32'(in_ready), 32'd1);
    chk("mid_urun", 32'(load_underrun), 32'd0);
    exp_q.delete();
    Load_En = 1'b0; shift_En = 1'b0; count_Load = 1'b0; out_En = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fresh operand after reset.
    run_op(1'b1, 8'h81, 8'h81, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
